// File: rtl/rv32m_mul_pkg.sv
// Shared encodings for the RV32M iterative Booth multiplier.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package rv32m_mul_pkg;

  // funct3[1:0] of the RV32M multiply group
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  // 34-bit extended multiplier -> 17 radix-4 digits
  localparam logic [4:0] BOOTH_DIGITS = 5'd17;

  // Booth triplet {b[2i+1], b[2i], b[2i-1]}
  localparam logic [2:0] BOOTH_T_Z0  = 3'b000;  // 0
  localparam logic [2:0] BOOTH_T_P1A = 3'b001;  // +A
  localparam logic [2:0] BOOTH_T_P1B = 3'b010;  // +A
  localparam logic [2:0] BOOTH_T_P2  = 3'b011;  // +2A
  localparam logic [2:0] BOOTH_T_M2  = 3'b100;  // -2A
  localparam logic [2:0] BOOTH_T_M1A = 3'b101;  // -A
  localparam logic [2:0] BOOTH_T_M1B = 3'b110;  // -A
  localparam logic [2:0] BOOTH_T_Z1  = 3'b111;  // 0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/booth_digit_select.sv
// Booth digit decode: triplet selects 0/+-A/+-2A, then shifted to digit weight.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module booth_digit_select
  import rv32m_mul_pkg::*;
(
  input  logic [2:0]  i_trip,
  input  logic [63:0] i_a,
  input  logic [5:0]  i_shift,
  output logic [63:0] o_mult
);

  logic [63:0] w_base;

  // Pick the signed multiple of A named by the triplet (mod 2^64)
  always_comb begin
    w_base = '0;
    case (i_trip)
      BOOTH_T_P1A, BOOTH_T_P1B: w_base = i_a;
      BOOTH_T_P2:               w_base = {i_a[62:0], 1'b0};
      BOOTH_T_M2:               w_base = -{i_a[62:0], 1'b0};
      BOOTH_T_M1A, BOOTH_T_M1B: w_base = -i_a;
      default:                  w_base = '0;
    endcase
  end

  assign o_mult = w_base << i_shift;

endmodule

// File: rtl/rv32m_booth_mul_seq.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU.
// Latency: ceil(17/DIGITS_PER_CYCLE)+1 cycles from accept to out_valid (1 with MUL_ZERO_SKIP_EN and a zero operand).
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there so back-to-back ops have no bubble.
module rv32m_booth_mul_seq
  import rv32m_mul_pkg::*;
#(
  parameter int DIGITS_PER_CYCLE = 1  // 1 or 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  mul_state_e  r_state;
  mul_state_e  w_state_nxt;

  logic [63:0] r_a;
  logic [33:0] r_b;
  logic [1:0]  r_op;
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;
  logic [31:0] r_result;

  logic        w_accept;
  logic        w_final;
  logic        w_zero;
  logic [34:0] w_bext;
  logic [63:0] w_acc_nxt;

  logic [4:0]  w_idx     [DIGITS_PER_CYCLE];
  logic        w_dig_vld [DIGITS_PER_CYCLE];
  logic [63:0] w_mult    [DIGITS_PER_CYCLE];

  // All digits retired: this CALC cycle only latches the result slice
  assign w_final  = (r_cnt >= BOOTH_DIGITS);
  assign w_accept = in_valid & in_ready;
  // B[-1] = 0 appended below bit 0
  assign w_bext   = {r_b, 1'b0};

`ifdef MUL_ZERO_SKIP_EN
  assign w_zero = (rs1 == 32'd0) || (rs2 == 32'd0);
`else
  assign w_zero = 1'b0;
`endif

  for (genvar k = 0; k < DIGITS_PER_CYCLE; k++) begin : g_dig
    logic [4:0] w_sel_idx;

    assign w_idx[k]     = r_cnt + 5'(k);
    // Digits past 16 (second slot of the last two-digit cycle) contribute nothing
    assign w_dig_vld[k] = (r_state == CALC) && (w_idx[k] < BOOTH_DIGITS);
    assign w_sel_idx    = w_dig_vld[k] ? w_idx[k] : 5'd0;

    booth_digit_select u_sel (
      .i_trip  (w_bext[{w_sel_idx, 1'b0} +: 3]),
      .i_a     (r_a),
      .i_shift ({w_sel_idx, 1'b0}),
      .o_mult  (w_mult[k])
    );
  end

  // Sum this cycle's digit multiples into the running product
  always_comb begin
    w_acc_nxt = r_acc;
    for (int k = 0; k < DIGITS_PER_CYCLE; k++) begin
      if (w_dig_vld[k]) w_acc_nxt = w_acc_nxt + w_mult[k];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; flush and reset override everything
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush && !rst) w_state_nxt = CALC;
      end
      CALC: begin
        if (w_final) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (in_valid && out_ready && !flush && !rst) w_state_nxt = CALC;
        else if (out_ready)                          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush || rst) begin
      in_ready    = 1'b0;
      w_state_nxt = IDLE;
    end
  end

  // Operand capture at accept, digit accumulation in CALC, result latch on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= MUL_OP_MUL;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a   <= (op == MUL_OP_MULH || op == MUL_OP_MULHSU) ?
               {{32{rs1[31]}}, rs1} : {32'd0, rs1};
      r_b   <= (op == MUL_OP_MULH) ? {{2{rs2[31]}}, rs2} : {2'b00, rs2};
      r_op  <= op;
      r_acc <= '0;
      // A zero operand jumps straight to the finalize cycle with acc=0
      r_cnt <= w_zero ? BOOTH_DIGITS : 5'd0;
    end else if (r_state == CALC && !flush) begin
      if (w_final) begin
        r_result <= (r_op == MUL_OP_MUL) ? r_acc[31:0] : r_acc[63:32];
      end else begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 5'(DIGITS_PER_CYCLE);
      end
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_rv32m_booth_mul_seq.sv
// Bench for rv32m_booth_mul_seq: one-digit and two-digit instances against a 64-bit arithmetic model.
// Latency: checks 18 / 10 cycle accept-to-valid (1 with MUL_ZERO_SKIP_EN and a zero operand).
// Backpressure: holds out_ready low in DONE, then takes result and issues in the same cycle.
module tb_rv32m_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid1, in_valid2;
  logic        in_ready1, in_ready2;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        out_valid1, out_valid2;
  logic        out_ready;
  logic [31:0] result1, result2;
  logic        busy1, busy2;
  logic        sel;  // 0: one-digit instance, 1: two-digit instance

  logic        ov, ir, bz;
  logic [31:0] res;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rv32m_booth_mul_seq #(.DIGITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .op(op), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .busy(busy1)
  );

  rv32m_booth_mul_seq #(.DIGITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid2), .out_ready(out_ready),
    .result(result2), .busy(busy2)
  );

  assign ov  = sel ? out_valid2 : out_valid1;
  assign ir  = sel ? in_ready2  : in_ready1;
  assign bz  = sel ? busy2      : busy1;
  assign res = sel ? result2    : result1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: extend operands per op, full 64-bit product, pick the slice
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int full_lat(input logic s);
    return s ? 10 : 18;
  endfunction

  function automatic int exp_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_SKIP_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return full_lat(s);
  endfunction

  // Called at a negedge with the selected unit ready; returns after the accept edge
  task automatic issue(input logic s, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    sel = s;
    op  = o;
    rs1 = a;
    rs2 = b;
    if (s) in_valid2 = 1'b1;
    else   in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
    rs1 = $urandom;  // later operand changes must be ignored
    rs2 = $urandom;
    op  = 2'($urandom_range(0, 3));
  endtask

  // Counts cycles from the accept edge until out_valid, then checks latency and value
  task automatic wait_res(input string tag, input int lat_exp, input logic [31:0] res_exp);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!ov && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    check({tag, "_res"}, {32'd0, res}, {32'd0, res_exp});
  endtask

  task automatic run_op(input string tag, input logic s, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    @(negedge clk);
    issue(s, o, a, b);
    wait_res(tag, exp_lat(s, a, b), r);
  endtask

  // Starts an op, kills it in CALC with flush (k=0) or rst (k=1), checks nothing escapes
  task automatic kill_test(input string tag, input logic use_rst);
    logic seen;
    @(negedge clk);
    out_ready = 1'b1;
    issue(1'b0, 2'b11, 32'h1234_5678, 32'h0000_0009);
    repeat (6) @(negedge clk);
    in_valid1 = 1'b1;
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    #1;
    check({tag, "_inrdy_during"}, {63'd0, in_ready1}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush = 1'b0;
    in_valid1 = 1'b0;
    @(negedge clk);
    check({tag, "_after"}, {61'd0, in_ready1, busy1, out_valid1}, {61'd0, 3'b100});
    if (use_rst) check({tag, "_res_cleared"}, {32'd0, result1}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid1) seen = 1'b1;
    end
    check({tag, "_no_result"}, {63'd0, seen}, 64'd0);
    run_op({tag, "_next"}, 1'b0, 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; flush = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    op = 2'b00; rs1 = '0; rs2 = '0; out_ready = 1'b1; sel = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_dut1", {29'd0, out_valid1, busy1, in_ready1, result1}, {29'd0, 3'b001, 32'd0});
    check("reset_dut2", {29'd0, out_valid2, busy2, in_ready2, result2}, {29'd0, 3'b001, 32'd0});

    // Directed slices on the one-digit instance
    run_op("mul_7xm3",   1'b0, 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh_min",   1'b0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu_max",  1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu_max", 1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_m1x2",  1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);

    // Backpressure: result must sit still in DONE while out_ready is low
    @(negedge clk);
    out_ready = 1'b0;
    issue(1'b0, 2'b00, 32'd9, 32'd9);
    wait_res("bp_first", 18, 32'd81);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {29'd0, out_valid1, busy1, in_ready1, result1}, {29'd0, 3'b110, 32'd81});
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid1 = 1'b1;
    op = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
    #1;
    check("bp_inrdy", {63'd0, in_ready1}, 64'd1);
    in_valid1 = 1'b0;
    issue(1'b0, 2'b00, 32'd3, 32'd5);
    wait_res("bp_next", 18, 32'h0000_000F);

    kill_test("flush", 1'b0);
    kill_test("rst", 1'b1);

    // Zero operand on both widths
    run_op("zero_d1", 1'b0, 2'b00, 32'd0, 32'h0000_1234, 32'd0);
    run_op("zero_d2", 1'b1, 2'b00, 32'd0, 32'h0000_1234, 32'd0);

    // Two-digit instance against the arithmetic model
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i == 0) begin ra = 32'h8000_0000; rb = 32'h7FFF_FFFF; end
      if (i == 1) begin ra = 32'hFFFF_FFFF; rb = 32'h8000_0000; end
      run_op($sformatf("rand_d2_%0d_op%0d", i, ro), 1'b1, ro, ra, rb, ref_mul(ro, ra, rb));
    end

    // A few random ops on the one-digit instance as well
    for (int i = 0; i < 4; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      run_op($sformatf("rand_d1_%0d_op%0d", i, ro), 1'b0, ro, ra, rb, ref_mul(ro, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
